// File: rtl/mem_access.sv
// mem_access: memory-stage load/store engine on a req/ack data port; optional MEM_ALIGN_CHECK_EN rejects misaligned HALF/WORD.
// Latency: 3 cycles minimum (IDLE, BUSY until ack or TIMEOUT_CYCLES, DONE); stall is high on every cycle but DONE.
// Backpressure: dmem_req and all dmem_* fields stay stable until dmem_ack; upstream is frozen via stall meanwhile.
module mem_access #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int L_S_MODE_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  mem_read_en,
    input  logic                  mem_write_en,
    input  logic [L_S_MODE_W-1:0] l_s_mode,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  bus_err,
    output logic                  addr_err,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [31:0]           dmem_addr,
    output logic [3:0]            dmem_be,
    output logic [31:0]           dmem_wdata,
    input  logic                  dmem_ack,
    input  logic [31:0]           dmem_rdata
);
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE   = L_S_MODE_W'(0);
    localparam logic [L_S_MODE_W-1:0] L_S_BYTE_U = L_S_MODE_W'(1);
    localparam logic [L_S_MODE_W-1:0] L_S_HALF   = L_S_MODE_W'(2);
    localparam logic [L_S_MODE_W-1:0] L_S_HALF_U = L_S_MODE_W'(3);
    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

    state_e                state_q, state_d;
    logic [31:0]           addr_q, addr_d;
    logic [L_S_MODE_W-1:0] mode_q, mode_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  rd_q, rd_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [31:0]           load_data_q, load_data_d;
    logic                  bus_err_q, bus_err_d;
    logic                  addr_err_q, addr_err_d;

    logic                  access;
    logic                  misaligned;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           rd_fmt;

    assign access = ex_valid & (mem_read_en | mem_write_en);

`ifdef MEM_ALIGN_CHECK_EN
    // Misaligned HALF/WORD accesses are rejected before any bus request
    always_comb begin
        misaligned = 1'b0;
        if (l_s_mode == L_S_HALF || l_s_mode == L_S_HALF_U) begin
            misaligned = addr[0];
        end else if (l_s_mode != L_S_BYTE && l_s_mode != L_S_BYTE_U) begin
            misaligned = (addr[1:0] != 2'b00);
        end
    end
`else
    assign misaligned = 1'b0;
`endif

    // Select the addressed lane of the read data and extend it per the latched mode
    always_comb begin
        case (addr_q[1:0])
            2'd0:    rd_byte = dmem_rdata[7:0];
            2'd1:    rd_byte = dmem_rdata[15:8];
            2'd2:    rd_byte = dmem_rdata[23:16];
            default: rd_byte = dmem_rdata[31:24];
        endcase
        rd_half = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (mode_q)
            L_S_BYTE:   rd_fmt = {{24{rd_byte[7]}}, rd_byte};
            L_S_BYTE_U: rd_fmt = {24'd0, rd_byte};
            L_S_HALF:   rd_fmt = {{16{rd_half[15]}}, rd_half};
            L_S_HALF_U: rd_fmt = {16'd0, rd_half};
            default:    rd_fmt = dmem_rdata;
        endcase
    end

    // State and datapath registers; async reset drops the request at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            mode_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            rd_q        <= 1'b0;
            cnt_q       <= '0;
            load_data_q <= '0;
            bus_err_q   <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mode_q      <= mode_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            bus_err_q   <= bus_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    // Next-state: latch on accept, count BUSY cycles, resolve ack or timeout into DONE
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        mode_d      = mode_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        bus_err_d   = 1'b0;
        addr_err_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    addr_d  = addr;
                    mode_d  = l_s_mode;
                    wdata_d = wdata;
                    we_d    = mem_write_en;
                    rd_d    = ~mem_write_en;
                    cnt_d   = '0;
                    if (misaligned) begin
                        state_d     = S_DONE;
                        addr_err_d  = 1'b1;
                        load_data_d = '0;
                    end else begin
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_ack) begin
                    state_d = S_DONE;
                    if (rd_q) begin
                        load_data_d = rd_fmt;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    bus_err_d   = 1'b1;
                    load_data_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: bus fields only while BUSY, pulses only in DONE
    always_comb begin
        stall      = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        dmem_addr  = '0;
        dmem_be    = '0;
        dmem_wdata = '0;
        load_valid = 1'b0;
        bus_err    = 1'b0;
        addr_err   = 1'b0;
        load_data  = load_data_q;
        case (state_q)
            S_IDLE: begin
                stall = access & rst_n;
            end
            S_BUSY: begin
                stall     = 1'b1;
                dmem_req  = 1'b1;
                dmem_we   = we_q;
                dmem_addr = {addr_q[31:2], 2'b00};
                case (mode_q)
                    L_S_BYTE, L_S_BYTE_U: begin
                        dmem_be    = 4'b0001 << addr_q[1:0];
                        dmem_wdata = {4{wdata_q[7:0]}};
                    end
                    L_S_HALF, L_S_HALF_U: begin
                        dmem_be    = 4'b0011 << {addr_q[1], 1'b0};
                        dmem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        dmem_be    = 4'b1111;
                        dmem_wdata = wdata_q;
                    end
                endcase
            end
            default: begin
                load_valid = rd_q & ~bus_err_q & ~addr_err_q;
                bus_err    = bus_err_q;
                addr_err   = addr_err_q;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;
    localparam int TO = 4;
    localparam logic [2:0] M_B = 3'd0, M_BU = 3'd1, M_H = 3'd2, M_HU = 3'd3, M_W = 3'd4;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ex_valid = 1'b0, mem_read_en = 1'b0, mem_write_en = 1'b0;
    logic [2:0] l_s_mode = 3'd0;
    logic [31:0] addr = '0, wdata = '0, dmem_rdata = '0;
    logic dmem_ack = 1'b0;
    logic stall, load_valid, bus_err, addr_err, dmem_req, dmem_we;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0] dmem_be;

    mem_access #(.TIMEOUT_CYCLES(TO), .L_S_MODE_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .mem_read_en(mem_read_en),
        .mem_write_en(mem_write_en), .l_s_mode(l_s_mode), .addr(addr), .wdata(wdata),
        .stall(stall), .load_data(load_data), .load_valid(load_valid), .bus_err(bus_err),
        .addr_err(addr_err), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] a; logic [3:0] be; logic [31:0] wd; int n; } req_t;
    typedef struct { logic lv; logic [31:0] ld; logic be; logic ae; int st; } done_t;

    req_t  req_q[$];
    done_t done_q[$];
    int checks = 0, failures = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void push_req(logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd, int n);
        req_t r;
        r.we = we; r.a = a; r.be = be; r.wd = wd; r.n = n;
        req_q.push_back(r);
    endfunction

    function automatic void push_done(logic lv, logic [31:0] ld, logic be, logic ae, int st);
        done_t d;
        d.lv = lv; d.ld = ld; d.be = be; d.ae = ae; d.st = st;
        done_q.push_back(d);
    endfunction

    // Monitor: compares requests and completions against the scoreboard queues
    req_t  cur;
    done_t dn;
    logic  prev_req = 1'b0, prev_stall = 1'b0;
    int    req_cnt = 0, stall_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0; prev_stall = 1'b0; req_cnt = 0; stall_cnt = 0;
        end else begin
            if (dmem_req && !prev_req) begin
                if (req_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req: got req addr 0x%08h expected none", dmem_addr);
                end else begin
                    cur = req_q.pop_front();
                    req_cnt = 0;
                    chk("req_we", {31'd0, dmem_we}, {31'd0, cur.we});
                    chk("req_addr", dmem_addr, cur.a);
                    chk("req_be", {28'd0, dmem_be}, {28'd0, cur.be});
                    chk("req_wdata", dmem_wdata, cur.wd);
                end
            end else if (dmem_req) begin
                chk("req_hold_addr", dmem_addr, cur.a);
                chk("req_hold_be", {28'd0, dmem_be}, {28'd0, cur.be});
            end
            if (dmem_req) req_cnt++;
            if (!dmem_req && prev_req) chk("req_cycles", req_cnt, cur.n);
            if (stall) stall_cnt++;
            if (prev_stall && !stall) begin
                if (done_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    dn = done_q.pop_front();
                    chk("load_valid", {31'd0, load_valid}, {31'd0, dn.lv});
                    chk("load_data", load_data, dn.ld);
                    chk("bus_err", {31'd0, bus_err}, {31'd0, dn.be});
                    chk("addr_err", {31'd0, addr_err}, {31'd0, dn.ae});
                    chk("stall_cycles", stall_cnt, dn.st);
                end
                stall_cnt = 0;
            end else if (load_valid || bus_err || addr_err) begin
                failures++;
                $display("FAIL stray_pulse: got lv=%0b be=%0b ae=%0b expected none", load_valid, bus_err, addr_err);
            end
            prev_req = dmem_req; prev_stall = stall;
        end
    end

    // Drive one instruction, answer the bus at BUSY cycle ack_at (0 = never), end back in IDLE
    task automatic drive(input bit rd, input bit wr, input logic [2:0] mode, input logic [31:0] a,
                         input logic [31:0] wd, input int ack_at, input logic [31:0] rdat, input bit has_req);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read_en = rd; mem_write_en = wr; l_s_mode = mode; addr = a; wdata = wd;
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_read_en = 1'b0; mem_write_en = 1'b0;
        if (has_req) begin
            if (ack_at > 0) begin
                repeat (ack_at - 1) begin @(posedge clk); #1; end
                dmem_ack = 1'b1; dmem_rdata = rdat;
                @(posedge clk); #1;
                dmem_ack = 1'b0; dmem_rdata = '0;
            end else begin
                repeat (TO) begin @(posedge clk); #1; end
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_pulses", {29'd0, load_valid, bus_err, addr_err}, 32'd0);
        chk("rst_be", {28'd0, dmem_be}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;

        push_req(1'b0, 32'h100, 4'b1111, 32'h0, 3); push_done(1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 4);
        drive(1, 0, M_W, 32'h100, 32'h0, 3, 32'hDEADBEEF, 1);

        push_req(1'b0, 32'h100, 4'b1000, 32'h0, 1); push_done(1'b1, 32'hFFFFFF80, 1'b0, 1'b0, 2);
        drive(1, 0, M_B, 32'h103, 32'h0, 1, 32'h80123456, 1);

        push_req(1'b0, 32'h100, 4'b1000, 32'h0, 1); push_done(1'b1, 32'h00000080, 1'b0, 1'b0, 2);
        drive(1, 0, M_BU, 32'h103, 32'h0, 1, 32'h80123456, 1);

        push_req(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 1); push_done(1'b0, 32'h00000080, 1'b0, 1'b0, 2);
        drive(0, 1, M_H, 32'h102, 32'h1234ABCD, 1, 32'h0, 1);

        push_req(1'b0, 32'h100, 4'b1100, 32'h0, 2); push_done(1'b1, 32'hFFFF8001, 1'b0, 1'b0, 3);
        drive(1, 0, M_H, 32'h102, 32'h0, 2, 32'h80011234, 1);

        push_req(1'b0, 32'h100, 4'b0011, 32'h0, 1); push_done(1'b1, 32'h00001234, 1'b0, 1'b0, 2);
        drive(1, 0, M_HU, 32'h100, 32'h0, 1, 32'h80011234, 1);

        push_req(1'b1, 32'h100, 4'b0010, 32'h5A5A5A5A, 1); push_done(1'b0, 32'h00001234, 1'b0, 1'b0, 2);
        drive(0, 1, M_B, 32'h101, 32'h0000005A, 1, 32'h0, 1);

        // read and write both set: the store wins
        push_req(1'b1, 32'h104, 4'b1111, 32'hCAFEF00D, 1); push_done(1'b0, 32'h00001234, 1'b0, 1'b0, 2);
        drive(1, 1, M_W, 32'h104, 32'hCAFEF00D, 1, 32'h0, 1);

        // no ack: abort after TO BUSY cycles
        push_req(1'b0, 32'h200, 4'b1111, 32'h0, TO); push_done(1'b0, 32'h0, 1'b1, 1'b0, TO + 1);
        drive(1, 0, M_W, 32'h200, 32'h0, 0, 32'h0, 1);

        // non-access instruction and a load without ex_valid
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read_en = 1'b0; mem_write_en = 1'b0; l_s_mode = M_W; addr = 32'h300;
        #1 chk("nop_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("nop_req", {31'd0, dmem_req}, 32'd0);
        ex_valid = 1'b0; mem_read_en = 1'b1;
        #1 chk("novalid_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1;
        chk("novalid_req", {31'd0, dmem_req}, 32'd0);
        mem_read_en = 1'b0;

`ifdef MEM_ALIGN_CHECK_EN
        push_done(1'b0, 32'h0, 1'b0, 1'b1, 1);
        drive(1, 0, M_W, 32'h102, 32'h0, 0, 32'h0, 0);
`else
        push_req(1'b0, 32'h100, 4'b1111, 32'h0, 1); push_done(1'b1, 32'hA5A50F0F, 1'b0, 1'b0, 2);
        drive(1, 0, M_W, 32'h102, 32'h0, 1, 32'hA5A50F0F, 1);
`endif

        // reset in the middle of BUSY
        push_req(1'b0, 32'h400, 4'b1111, 32'h0, 0);
        @(posedge clk); #1;
        ex_valid = 1'b1; mem_read_en = 1'b1; l_s_mode = M_W; addr = 32'h400;
        @(posedge clk); #1;
        ex_valid = 1'b0; mem_read_en = 1'b0;
        @(posedge clk); #1;
        chk("pre_rst_req", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, dmem_req}, 32'd0);
        chk("arst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1; dmem_ack = 1'b1; dmem_rdata = 32'h11111111;
        @(posedge clk); #1; dmem_ack = 1'b0; dmem_rdata = '0;
        chk("late_ack_quiet", {28'd0, stall, load_valid, bus_err, addr_err}, 32'd0);
        chk("late_ack_data", load_data, 32'd0);

        push_req(1'b0, 32'h100, 4'b1111, 32'h0, 1); push_done(1'b1, 32'h13579BDF, 1'b0, 1'b0, 2);
        drive(1, 0, M_W, 32'h100, 32'h0, 1, 32'h13579BDF, 1);

        @(posedge clk); #1;
        chk("req_q_drained", req_q.size(), 32'd0);
        chk("done_q_drained", done_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
